mono_data_tx: RTL and testbench
===============================

# mono_data_tx

Chip-side readout model for the MONOPIX token/read/freeze serial protocol: the transmitting end of `RX_TOKEN`/`RX_DATA` for the data receiver. It buffers injected hits and raises a token while hits are pending. Each rising edge on the DAQ's `RX_READ` shifts one hit word out MSB-first. It is used in simulation benches and in loop-back firmware builds, clocked by the same clock the receiver uses as `RX_CLK`.

## Interface
- `DEPTH`, 16, hit buffer depth in words; power of two, 2..256
- `RX_CLK`  in  1  serial/readout clock; one data bit per cycle
- `RST`  in  1  synchronous, active-high reset
- `HIT_VALID`  in  1  hit offered this cycle
- `HIT_DATA`  in  27  {col[5:0], row[8:0], le[5:0], te[5:0]}
- `HIT_READY`  out  1  hit accepted when `HIT_VALID & HIT_READY`
- `RX_READ`  in  1  read request from DAQ; rising edge starts one word
- `RX_FREEZE`  in  1  freeze from DAQ; blocks hit acceptance
- `RX_TOKEN`  out  1  hits pending or word in flight
- `RX_DATA`  out  1  serial data, MSB first
- `READ_ERR`  out  1  one-cycle pulse on an invalid read edge
- `WORD_CNT`  out  16  words fully transmitted, wraps at 2^16

## Operation
- Read edge: `rd_edge = RX_READ & ~read_q`, where `read_q` is `RX_READ` registered.
- States:
  - IDLE: on `rd_edge` with buffer non-empty, pop the head, load the shift register, load the bit counter with `LEN-1`, go to SHIFT. `LEN` = 27, or 28 with parity.
  - SHIFT: each cycle shift left and decrement. When the counter reaches 0, the next edge returns to IDLE and increments `WORD_CNT`.
- `rd_edge` while in SHIFT, or in IDLE with the buffer empty: ignored, `READ_ERR` pulses for one cycle. The transfer in progress is unaffected.
- `RX_DATA` = shift register MSB in SHIFT; 0 in IDLE.
- `RX_TOKEN` (registered) = buffer non-empty OR state is SHIFT.
- `HIT_READY` = `~RX_FREEZE & ~full`, combinational.
  - At full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with the buffer not full: both take effect, count unchanged.
- Freeze does not stop an ongoing shift or block new reads; it only stalls hit acceptance.

## Timing
- Reset values: `RX_TOKEN`=0, `RX_DATA`=0, `HIT_READY` follows `~RX_FREEZE` (buffer empty), `READ_ERR`=0, `WORD_CNT`=0, state IDLE, buffer empty, `read_q`=0.
- Reset in mid-SHIFT discards the word without counting it. `RX_DATA` and `RX_TOKEN` are 0 after that edge.
- Hit accepted at edge k: `RX_TOKEN`=1 after edge k+1.
- `rd_edge` sampled at edge n:
  - bit 26 (col MSB) is valid after edge n;
  - bit 0 is valid after edge n+26;
  - IDLE after edge n+27, with `RX_DATA`=0.
  - With parity, add one cycle.
- `WORD_CNT` updates at the SHIFT→IDLE edge.
- The earliest accepted next read edge is the cycle after the return to IDLE. `RX_READ` must be low for ≥1 sampled cycle between reads.
- `RX_TOKEN` falls the edge after the last word's SHIFT→IDLE, provided the buffer is empty.

## Configuration
- `MONO_TX_PARITY_EN` defined:
  - an even-parity bit (`^word`) is shifted after bit 0;
  - `LEN`=28, SHIFT lasts 28 cycles.
- Not defined:
  - `LEN`=27, no parity cycle.

## Structure
- Package `mono_tx_pkg`:
  - field widths `COL_W`=6, `ROW_W`=9, `LE_W`=6, `TE_W`=6, `WORD_W`=27;
  - state enum {IDLE, SHIFT};
  - `LEN` derived from `WORD_W` and the macro.
- Sub-module `mono_tx_fifo`: synchronous FIFO, `DEPTH`×`WORD_W`, first-word-fall-through head, full/empty flags, count width `$clog2(DEPTH)+1`.

## Test plan
- Inject one hit `{col=5, row=300, le=10, te=20}`, then pulse read → `RX_TOKEN` rises; 27 bits `0x05,0x12C,0x0A,0x14` arrive MSB-first starting the cycle after the edge; then `RX_TOKEN`=0 and `WORD_CNT`=1.
- Inject 3 hits, issue 3 reads spaced by 30 cycles → words arrive in injection order, `WORD_CNT`=3, token low afterwards; a 4th read gives a `READ_ERR` pulse and `RX_DATA` stays 0.
- Read edge at bit 10 of a transfer → `READ_ERR` pulses once; the current word completes unchanged.
- `RX_FREEZE`=1 with `HIT_VALID` held → `HIT_READY`=0 and nothing is accepted; on release the hit is accepted in the next cycle.
- Push 16 hits with no reads → `HIT_READY`=0 on the 17th. Push and read in the same cycle at full → push refused, count drops to 15.
- Assert `RST` at bit 13 of a transfer → next cycle `RX_DATA`=0, `RX_TOKEN`=0, `WORD_CNT` unchanged. With `MONO_TX_PARITY_EN`, word `0x0000001` → 28th bit = 1.

Source files
------------

// File: rtl/mono_tx_pkg.sv
// mono_tx_pkg: hit word layout, serial length and readout states; MONO_TX_PARITY_EN appends an even-parity bit.
package mono_tx_pkg;
  localparam int COL_W = 6;
  localparam int ROW_W = 9;
  localparam int LE_W = 6;
  localparam int TE_W = 6;
  localparam int WORD_W = COL_W + ROW_W + LE_W + TE_W;
`ifdef MONO_TX_PARITY_EN
  localparam int LEN = WORD_W + 1;
`else
  localparam int LEN = WORD_W;
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/mono_tx_fifo.sv
// mono_tx_fifo: synchronous first-word-fall-through hit buffer with full/empty flags.
module mono_tx_fifo
  import mono_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WORD_W-1:0]       din,
  output logic [WORD_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  // DEPTH is a power of two, so the count MSB alone marks full
  assign full = count[AW];
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mono_data_tx.sv
// mono_data_tx: MONOPIX token/read/freeze serial transmitter; MONO_TX_PARITY_EN adds a trailing even-parity bit.
module mono_data_tx
  import mono_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              RX_CLK,
  input  logic              RST,
  input  logic              HIT_VALID,
  input  logic [WORD_W-1:0] HIT_DATA,
  output logic              HIT_READY,
  input  logic              RX_READ,
  input  logic              RX_FREEZE,
  output logic              RX_TOKEN,
  output logic              RX_DATA,
  output logic              READ_ERR,
  output logic [15:0]       WORD_CNT
);
  localparam int CW = $clog2(LEN);
  state_t state;
  logic read_q, rd_edge, start, full, empty;
  logic [WORD_W-1:0] head;
  logic [LEN-1:0] sr, load_word;
  logic [CW-1:0] bit_cnt;
  logic [$clog2(DEPTH):0] count;
  assign HIT_READY = ~RX_FREEZE & ~full;
  assign rd_edge = RX_READ & ~read_q;
  assign start = rd_edge & (state == IDLE) & ~empty;
  assign RX_DATA = (state == SHIFT) & sr[LEN-1];
`ifdef MONO_TX_PARITY_EN
  assign load_word = {head, ^head};
`else
  assign load_word = head;
`endif
  mono_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(RX_CLK), .rst(RST), .push(HIT_VALID & HIT_READY), .pop(start),
    .din(HIT_DATA), .head(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge RX_CLK) begin
    if (RST) begin
      state <= IDLE;
      read_q <= 1'b0;
      sr <= '0;
      bit_cnt <= '0;
      RX_TOKEN <= 1'b0;
      READ_ERR <= 1'b0;
      WORD_CNT <= '0;
    end else begin
      read_q <= RX_READ;
      RX_TOKEN <= ~empty | (state == SHIFT);
      READ_ERR <= rd_edge & ~start;
      if (state == IDLE) begin
        if (start) begin
          sr <= load_word;
          bit_cnt <= CW'(LEN - 1);
          state <= SHIFT;
        end
      end else if (bit_cnt == '0) begin
        state <= IDLE;
        WORD_CNT <= WORD_CNT + 1'b1;
      end else begin
        sr <= sr << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mono_data_tx.sv
// tb_mono_data_tx: directed and random readout of mono_data_tx against a queue-based word model.
module tb_mono_data_tx;
`ifdef MONO_TX_PARITY_EN
  localparam int LEN = 28;
`else
  localparam int LEN = 27;
`endif
  logic clk = 0, rst = 1, hit_valid = 0, rx_read = 0, rx_freeze = 0;
  logic [26:0] hit_data = '0;
  logic hit_ready, rx_token, rx_data, read_err;
  logic [15:0] word_cnt;
  int errors = 0, checks = 0, words = 0;
  logic [26:0] q[$];
  logic [26:0] w;

  always #5 clk = ~clk;

  mono_data_tx #(.DEPTH(16)) dut (
    .RX_CLK(clk), .RST(rst), .HIT_VALID(hit_valid), .HIT_DATA(hit_data),
    .HIT_READY(hit_ready), .RX_READ(rx_read), .RX_FREEZE(rx_freeze),
    .RX_TOKEN(rx_token), .RX_DATA(rx_data), .READ_ERR(read_err), .WORD_CNT(word_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LEN-1:0] frame(input logic [26:0] v);
`ifdef MONO_TX_PARITY_EN
    return {v, ^v};
`else
    return v;
`endif
  endfunction

  task automatic push_hit(input logic [26:0] v);
    hit_valid = 1;
    hit_data = v;
    #1;
    check("hit_ready", hit_ready, 1);
    tick;
    hit_valid = 0;
    q.push_back(v);
  endtask

  task automatic read_word(input int err_at);
    logic [LEN-1:0] got;
    logic [26:0] v;
    int errs;
    v = q.pop_front();
    errs = 0;
    rx_read = 1;
    tick;
    rx_read = 0;
    hit_valid = 0;
    check("token_busy", rx_token, 1);
    for (int i = LEN - 1; i >= 0; i--) begin
      got[i] = rx_data;
      errs += int'(read_err);
      rx_read = (i == err_at);
      tick;
    end
    words++;
    check("word", 32'(got), 32'(frame(v)));
    check("err_pulses", errs, err_at >= 0 ? 1 : 0);
    check("idle_data", rx_data, 0);
    check("word_cnt", word_cnt, words);
  endtask

  initial begin
    tick;
    tick;
    rst = 0;
    check("rst_token", rx_token, 0);
    check("rst_data", rx_data, 0);
    check("rst_err", read_err, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_ready", hit_ready, 1);
    // reset partway through a word: nothing counted, lines drop
    push_hit(27'($urandom));
    tick;
    rx_read = 1;
    tick;
    rx_read = 0;
    repeat (13) tick;
    rst = 1;
    tick;
    rst = 0;
    q.delete();
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_token", rx_token, 0);
    check("mid_rst_cnt", word_cnt, 0);
    tick;
    check("post_rst_token", rx_token, 0);
    // single known hit
    w = {6'd5, 9'd300, 6'd10, 6'd20};
    push_hit(w);
    check("token_lag", rx_token, 0);
    tick;
    check("token_rise", rx_token, 1);
    read_word(-1);
    tick;
    check("token_fall", rx_token, 0);
    // three random hits, ordered readout, then an empty read
    for (int i = 0; i < 3; i++) push_hit(27'($urandom));
    for (int i = 0; i < 3; i++) begin
      read_word(-1);
      repeat (2) tick;
    end
    check("token_after3", rx_token, 0);
    rx_read = 1;
    tick;
    rx_read = 0;
    check("empty_err", read_err, 1);
    check("empty_data", rx_data, 0);
    tick;
    check("empty_err_clr", read_err, 0);
    check("empty_cnt", word_cnt, words);
    // read edge during a transfer
    push_hit(27'($urandom));
    tick;
    read_word(16);
    tick;
    // freeze stalls acceptance
    rx_freeze = 1;
    hit_valid = 1;
    hit_data = 27'($urandom);
    #1;
    check("freeze_ready", hit_ready, 0);
    repeat (3) tick;
    check("freeze_token", rx_token, 0);
    rx_freeze = 0;
    #1;
    check("unfreeze_ready", hit_ready, 1);
    tick;
    hit_valid = 0;
    q.push_back(hit_data);
    tick;
    check("unfreeze_token", rx_token, 1);
    read_word(-1);
    tick;
    // fill to full, then push refused during a pop
    for (int i = 0; i < 16; i++) push_hit(27'($urandom));
    hit_valid = 1;
    hit_data = 27'($urandom);
    #1;
    check("full_ready", hit_ready, 0);
    read_word(-1);
    check("after_pop_ready", hit_ready, 1);
    for (int i = 0; i < 15; i++) read_word(-1);
    tick;
    check("drain_token", rx_token, 0);
    // lone LSB set: odd parity word
    push_hit(27'd1);
    tick;
    read_word(-1);
    tick;
    check("final_token", rx_token, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
